// File: rtl/spi_flash_pkg.sv
// Shared opcodes and FSM encoding for the SPI flash burst reader.
package spi_flash_pkg;

  localparam logic [7:0] CMD_FAST_READ = 8'h0B;
  localparam logic [7:0] CMD_DUAL_READ = 8'h3B;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DUMMY,
    ST_DATA,
    ST_CSH
  } state_t;

  // Opcode for the selected lane mode.
  function automatic logic [7:0] read_opcode(input logic dual);
    return dual ? CMD_DUAL_READ : CMD_FAST_READ;
  endfunction

endpackage

// File: rtl/spi_rx_shifter.sv
// Byte capture shifter: LANES bits enter per SCK rise, MSB first.
// o_last flags that the next shift completes the byte; o_done pulses
// for one clk after the completing shift, with o_byte holding the byte.
module spi_rx_shifter #(
  parameter int LANES = 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [LANES-1:0] i_d,
  output logic [7:0]       o_byte,
  output logic             o_last,
  output logic             o_done
);

  localparam logic [2:0] LAST = 3'(8 / LANES - 1);

  logic [7:0] r_sh;
  logic [2:0] r_cnt;
  logic       r_done;

  // Shift register, per-byte bit counter and completion pulse.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sh   <= '0;
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else if (i_clr) begin
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_en) begin
        r_sh <= {r_sh[7-LANES:0], i_d};
        if (r_cnt == LAST) begin
          r_cnt  <= '0;
          r_done <= 1'b1;
        end else begin
          r_cnt <= r_cnt + 3'd1;
        end
      end
    end
  end

  assign o_byte = r_sh;
  assign o_last = (r_cnt == LAST);
  assign o_done = r_done;

endmodule

// File: rtl/spi_flash_burst_reader.sv
// Burst reader for serial NOR flash: one CS-low transaction of opcode,
// address, dummy cycles and len data bytes in single or dual-output mode.
// SCK runs at clk/2 and is held low before a byte's final rise while the
// consumer still holds the previous byte.
module spi_flash_burst_reader
  import spi_flash_pkg::*;
#(
  parameter int ADDR_W       = 24,
  parameter int LEN_W        = 16,
  parameter int DUMMY_CYCLES = 8,
  parameter int CS_HIGH_CLKS = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [ADDR_W-1:0] addr,
  input  logic [LEN_W-1:0]  len,
  input  logic              dual,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [7:0]        out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              spi_sck,
  output logic              spi_cs_n,
  output logic              io0_o,
  output logic              io0_oe,
  input  logic              io0_i,
  input  logic              io1_i
);

  localparam int         TX_W    = 8 + ADDR_W;
  localparam logic [7:0] C_CMD   = 8'd7;
  localparam logic [7:0] C_ADDR  = 8'(ADDR_W - 1);
  localparam logic [7:0] C_DUMMY = 8'(DUMMY_CYCLES - 1);
  localparam logic [7:0] C_CSH   = 8'(CS_HIGH_CLKS - 1);

  state_t            r_state, w_nxt_state;
  logic [7:0]        r_cnt, w_nxt_cnt;
  logic [TX_W-1:0]   r_tx, w_nxt_tx;
  logic [LEN_W-1:0]  r_left, w_nxt_left;
  logic              r_dual, w_nxt_dual;
  logic              r_sck, w_nxt_sck;
  logic              r_cs_n, w_nxt_cs_n;
  logic              r_io0_o, w_nxt_io0_o;
  logic              r_io0_oe, w_nxt_io0_oe;
  logic              r_busy, w_nxt_busy;
  logic              r_done, w_nxt_done;
  logic [7:0]        r_out_data;
  logic              r_out_valid;

  logic              w_load, w_rx_clr, w_stall, w_shift;
  logic [7:0]        w_byte1, w_byte2, w_byte;
  logic              w_last1, w_last2, w_last;
  logic              w_done1, w_done2, w_byte_done;
  logic [7:0]        w_op;

  assign w_op        = read_opcode(dual);
  assign w_byte      = r_dual ? w_byte2 : w_byte1;
  assign w_last      = r_dual ? w_last2 : w_last1;
  assign w_byte_done = r_dual ? w_done2 : w_done1;

  // Stall only while SCK is low ahead of a byte's final rise.
  assign w_stall = (r_state == ST_DATA) && !r_sck && w_last && r_out_valid && !out_ready;
  assign w_shift = (r_state == ST_DATA) && !abort && !r_sck && !w_stall;

  spi_rx_shifter #(.LANES(1)) u_rx1 (
    .clk    (clk),
    .rstn   (rstn),
    .i_clr  (w_rx_clr),
    .i_en   (w_shift && !r_dual),
    .i_d    (io1_i),
    .o_byte (w_byte1),
    .o_last (w_last1),
    .o_done (w_done1)
  );

  spi_rx_shifter #(.LANES(2)) u_rx2 (
    .clk    (clk),
    .rstn   (rstn),
    .i_clr  (w_rx_clr),
    .i_en   (w_shift && r_dual),
    .i_d    ({io1_i, io0_i}),
    .o_byte (w_byte2),
    .o_last (w_last2),
    .o_done (w_done2)
  );

  // Next-state and next-output logic for the transaction FSM.
  always_comb begin
    w_nxt_state  = r_state;
    w_nxt_cnt    = r_cnt;
    w_nxt_tx     = r_tx;
    w_nxt_left   = r_left;
    w_nxt_dual   = r_dual;
    w_nxt_sck    = r_sck;
    w_nxt_cs_n   = r_cs_n;
    w_nxt_io0_o  = r_io0_o;
    w_nxt_io0_oe = r_io0_oe;
    w_nxt_busy   = r_busy;
    w_nxt_done   = 1'b0;
    w_load       = 1'b0;
    w_rx_clr     = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (start) begin
          if (len == '0) begin
            w_nxt_done = 1'b1;
          end else begin
            w_nxt_state  = ST_CMD;
            w_nxt_cnt    = '0;
            w_nxt_tx     = {w_op[6:0], addr, 1'b0};
            w_nxt_left   = len;
            w_nxt_dual   = dual;
            w_nxt_sck    = 1'b0;
            w_nxt_cs_n   = 1'b0;
            w_nxt_io0_o  = w_op[7];
            w_nxt_io0_oe = 1'b1;
            w_nxt_busy   = 1'b1;
            w_rx_clr     = 1'b1;
          end
        end
      end
      ST_CMD, ST_ADDR, ST_DUMMY, ST_DATA: begin
        if (abort) begin
          w_nxt_state  = ST_CSH;
          w_nxt_cnt    = '0;
          w_nxt_sck    = 1'b0;
          w_nxt_cs_n   = 1'b1;
          w_nxt_io0_o  = 1'b0;
          w_nxt_io0_oe = 1'b0;
          w_rx_clr     = 1'b1;
        end else begin
          if (!w_stall) w_nxt_sck = ~r_sck;
          // Everything below happens on the edge where SCK falls.
          if (r_sck) begin
            unique case (r_state)
              ST_CMD, ST_ADDR: begin
                w_nxt_io0_o = r_tx[TX_W-1];
                w_nxt_tx    = {r_tx[TX_W-2:0], 1'b0};
                if (r_state == ST_CMD && r_cnt == C_CMD) begin
                  w_nxt_state = ST_ADDR;
                  w_nxt_cnt   = '0;
                end else if (r_state == ST_ADDR && r_cnt == C_ADDR) begin
                  w_nxt_state = ST_DUMMY;
                  w_nxt_cnt   = '0;
                end else begin
                  w_nxt_cnt = r_cnt + 8'd1;
                end
              end
              ST_DUMMY: begin
                w_nxt_io0_oe = 1'b0;
                if (r_cnt == C_DUMMY) begin
                  w_nxt_state = ST_DATA;
                  w_nxt_cnt   = '0;
                end else begin
                  w_nxt_cnt = r_cnt + 8'd1;
                end
              end
              default: begin
                if (w_byte_done) begin
                  w_load     = 1'b1;
                  w_nxt_left = r_left - LEN_W'(1);
                  if (r_left == LEN_W'(1)) begin
                    w_nxt_state  = ST_CSH;
                    w_nxt_cnt    = '0;
                    w_nxt_sck    = 1'b0;
                    w_nxt_cs_n   = 1'b1;
                    w_nxt_io0_oe = 1'b0;
                  end
                end
              end
            endcase
          end
        end
      end
      ST_CSH: begin
        if (r_cnt == C_CSH) begin
          w_nxt_state = ST_IDLE;
          w_nxt_cnt   = '0;
          w_nxt_busy  = 1'b0;
          w_nxt_done  = 1'b1;
        end else begin
          w_nxt_cnt = r_cnt + 8'd1;
        end
      end
      default: w_nxt_state = ST_IDLE;
    endcase
  end

  // FSM state and registered SPI/control outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_tx     <= '0;
      r_left   <= '0;
      r_dual   <= 1'b0;
      r_sck    <= 1'b0;
      r_cs_n   <= 1'b1;
      r_io0_o  <= 1'b0;
      r_io0_oe <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_nxt_state;
      r_cnt    <= w_nxt_cnt;
      r_tx     <= w_nxt_tx;
      r_left   <= w_nxt_left;
      r_dual   <= w_nxt_dual;
      r_sck    <= w_nxt_sck;
      r_cs_n   <= w_nxt_cs_n;
      r_io0_o  <= w_nxt_io0_o;
      r_io0_oe <= w_nxt_io0_oe;
      r_busy   <= w_nxt_busy;
      r_done   <= w_nxt_done;
    end
  end

  // Output byte holding register; a new byte load beats the handshake clear.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
    end else if (w_load) begin
      r_out_data  <= w_byte;
      r_out_valid <= 1'b1;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign spi_sck   = r_sck;
  assign spi_cs_n  = r_cs_n;
  assign io0_o     = r_io0_o;
  assign io0_oe    = r_io0_oe;

endmodule
